// File: rtl/riscv_32i_control_pkg.sv
// Control-path types and funct3 encodings for the load/store unit.
package riscv_32i_control_pkg;
  typedef enum logic [1:0] {
    LSU_IDLE  = 2'd0,
    LSU_ISSUE = 2'd1,
    LSU_WAIT  = 2'd2,
    LSU_RESP  = 2'd3
  } lsu_state_t;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  localparam logic [2:0] LSU_SB = 3'b000;
  localparam logic [2:0] LSU_SH = 3'b001;
  localparam logic [2:0] LSU_SW = 3'b010;

  function automatic logic lsu_funct3_illegal(input logic we, input logic [2:0] funct3);
    if (we) return (funct3 > LSU_SW);
    return (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
  endfunction
endpackage

// File: rtl/riscv_32i_defs_pkg.sv
// Shared RV32I datapath types used across the core.
package riscv_32i_defs_pkg;
  typedef logic [31:0] word_t;
  typedef logic [3:0]  byte_sel_t;
endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and extract/extend for loads; purely combinational.
module lsu_align
  import riscv_32i_defs_pkg::*;
  import riscv_32i_control_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [1:0] addr_lo,
  input  word_t      wdata,
  input  word_t      rd_data,
  output byte_sel_t  wr_sel,
  output word_t      wr_data,
  output word_t      ld_data
);
  word_t shifted;

  always_comb begin
    wr_sel  = 4'b0000;
    wr_data = wdata;
    shifted = rd_data >> {addr_lo, 3'b000};
    ld_data = shifted;

    case (funct3)
      LSU_SB: begin
        wr_sel  = 4'b0001 << addr_lo;
        wr_data = {4{wdata[7:0]}};
      end
      LSU_SH: begin
        wr_sel  = 4'b0011 << addr_lo;
        wr_data = {2{wdata[15:0]}};
      end
      LSU_SW:  wr_sel = 4'b1111;
      default: wr_sel = 4'b0000;
    endcase

    case (funct3)
      LSU_B:   ld_data = {{24{shifted[7]}}, shifted[7:0]};
      LSU_H:   ld_data = {{16{shifted[15]}}, shifted[15:0]};
      LSU_BU:  ld_data = {24'd0, shifted[7:0]};
      LSU_HU:  ld_data = {16'd0, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between memory-stage control and a synchronous data memory.
module load_store_unit
  import riscv_32i_defs_pkg::*;
  import riscv_32i_control_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_we,
  input  logic [2:0] req_funct3,
  input  word_t      req_addr,
  input  word_t      req_wdata,
  output logic       rsp_valid,
  output word_t      rsp_rdata,
  output logic       rsp_misaligned,
  output logic       rsp_illegal,
  output byte_sel_t  mem_wr_sel,
  output word_t      mem_addr,
  output word_t      mem_wr_data,
  input  word_t      mem_rd_data
);
  localparam logic [1:0] CNT_INIT = 2'(RD_LATENCY - 1);

  lsu_state_t state_q, state_d;
  logic       we_q, we_d;
  logic [2:0] funct3_q, funct3_d;
  word_t      addr_q, addr_d;
  word_t      wdata_q, wdata_d;
  logic [1:0] cnt_q, cnt_d;
  word_t      rdata_q, rdata_d;
  logic       mis_q, mis_d;
  logic       ill_q, ill_d;

  logic       req_ill, req_mis;
  byte_sel_t  align_sel;
  word_t      align_wdata, align_ld;

  lsu_align u_align (
    .funct3  (funct3_q),
    .addr_lo (addr_q[1:0]),
    .wdata   (wdata_q),
    .rd_data (mem_rd_data),
    .wr_sel  (align_sel),
    .wr_data (align_wdata),
    .ld_data (align_ld)
  );

  always_comb begin
    req_ill = lsu_funct3_illegal(req_we, req_funct3);
    req_mis = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
              ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    mis_d    = mis_q;
    ill_d    = ill_q;

    unique case (state_q)
      LSU_IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          rdata_d  = '0;
          // An illegal funct3 masks any alignment complaint.
          ill_d    = req_ill;
          mis_d    = !req_ill && req_mis;
          state_d  = (req_ill || req_mis) ? LSU_RESP : LSU_ISSUE;
        end
      end
      LSU_ISSUE: begin
        if (we_q) begin
          state_d = LSU_RESP;
        end else begin
          cnt_d   = CNT_INIT;
          state_d = LSU_WAIT;
        end
      end
      LSU_WAIT: begin
        if (cnt_q == 2'd0) begin
          rdata_d = align_ld;
          state_d = LSU_RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      LSU_RESP: state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= LSU_IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= 2'd0;
      rdata_q  <= '0;
      mis_q    <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      mis_q    <= mis_d;
      ill_q    <= ill_d;
    end
  end

  assign req_ready      = (state_q == LSU_IDLE);
  assign rsp_valid      = (state_q == LSU_RESP);
  assign rsp_rdata      = rdata_q;
  assign rsp_misaligned = mis_q;
  assign rsp_illegal    = ill_q;
  // Write enables are decoded from state so a reset edge in ISSUE still lets the store land.
  assign mem_wr_sel     = ((state_q == LSU_ISSUE) && we_q) ? align_sel : 4'b0000;
  assign mem_addr       = {addr_q[31:2], 2'b00};
  assign mem_wr_data    = align_wdata;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: latency-1 and latency-3 instances checked against a cycle-scheduled model.
module tb_load_store_unit;
  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata, rd_word;
  logic        rv      [2];
  logic        ready_w [2];
  logic        rspv_w  [2];
  logic [31:0] rdata_w [2];
  logic        mis_w   [2];
  logic        ill_w   [2];
  logic [3:0]  sel_w   [2];
  logic [31:0] maddr_w [2];
  logic [31:0] mwd_w   [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    load_store_unit #(.RD_LATENCY(g == 0 ? 1 : 3)) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_valid      (rv[g]),
      .req_ready      (ready_w[g]),
      .req_we         (req_we),
      .req_funct3     (req_funct3),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .rsp_valid      (rspv_w[g]),
      .rsp_rdata      (rdata_w[g]),
      .rsp_misaligned (mis_w[g]),
      .rsp_illegal    (ill_w[g]),
      .mem_wr_sel     (sel_w[g]),
      .mem_addr       (maddr_w[g]),
      .mem_wr_data    (mwd_w[g]),
      .mem_rd_data    (rd_word)
    );
  end

  typedef struct {
    bit          ill;
    bit          mis;
    logic [3:0]  sel;
    logic [31:0] wd;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  // Response lateness is measured from the accept cycle.
  function automatic exp_t predict(bit we, logic [2:0] f3, logic [31:0] a, logic [31:0] wdat,
                                   logic [31:0] rw, int lat_rd);
    exp_t e;
    int off, nb;
    logic [31:0] mask, v;
    e.ill = 0; e.mis = 0; e.sel = 4'h0; e.wd = 32'h0; e.rdata = 32'h0; e.lat = 0;
    off = int'(a[1:0]);
    nb  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    e.ill = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6);
    e.mis = !e.ill && ((off % nb) != 0);
    if (e.ill || e.mis) begin
      e.lat = 1;
    end else if (we) begin
      e.lat = 2;
      for (int k = 0; k < 4; k++) begin
        e.sel[k] = (k >= off) && (k < off + nb);
        e.wd[8*k +: 8] = wdat[8*(k % nb) +: 8];
      end
    end else begin
      e.lat = 2 + lat_rd;
      mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8*nb)) - 32'h1);
      v = (rw >> (8*off)) & mask;
      if (!f3[2] && nb < 4 && v[8*nb-1]) v = v | ~mask;
      e.rdata = v;
    end
    return e;
  endfunction

  int   n_chk = 0, n_pass = 0;
  int   cyc = 0;
  bit   started = 0;
  bit   have   [2];
  int   acc    [2];
  int   iss_at [2];
  int   rsp_at [2];
  bit   m_we   [2];
  logic [31:0] m_addr [2];
  exp_t m_e    [2];
  int   last_lat [2];
  logic [31:0] last_rdata [2];
  logic last_mis [2], last_ill [2];
  logic [3:0]  last_sel [2];
  logic [31:0] last_maddr [2], last_mwd [2];

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Model: tracks accepts and schedules ISSUE/response cycles.
  initial begin
    have[0] = 0; have[1] = 0;
    forever begin
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!rst_n) begin
          have[i] = 0;
        end else if (rv[i] && !(have[i] && cyc <= rsp_at[i])) begin
          have[i]   = 1;
          acc[i]    = cyc;
          m_e[i]    = predict(req_we, req_funct3, req_addr, req_wdata, rd_word, i == 0 ? 1 : 3);
          m_we[i]   = req_we;
          m_addr[i] = req_addr;
          iss_at[i] = (m_e[i].ill || m_e[i].mis) ? -1 : cyc + 1;
          rsp_at[i] = cyc + m_e[i].lat;
        end
      end
      if (!rst_n) started = 1;
      cyc++;
    end
  end

  // Compare: every cycle after the first reset edge.
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        for (int i = 0; i < 2; i++) begin
          bit busy, issue, resp;
          busy  = have[i] && cyc <= rsp_at[i];
          issue = have[i] && cyc == iss_at[i];
          resp  = have[i] && cyc == rsp_at[i];
          chk($sformatf("ready%0d", i), 32'(ready_w[i]), 32'(!busy));
          chk($sformatf("rsp_valid%0d", i), 32'(rspv_w[i]), 32'(resp));
          chk($sformatf("wr_sel%0d", i), 32'(sel_w[i]), 32'((issue && m_we[i]) ? m_e[i].sel : 4'h0));
          if (issue) begin
            chk($sformatf("mem_addr%0d", i), maddr_w[i], {m_addr[i][31:2], 2'b00});
            if (m_we[i]) chk($sformatf("wr_data%0d", i), mwd_w[i], m_e[i].wd);
            last_sel[i] = sel_w[i]; last_maddr[i] = maddr_w[i]; last_mwd[i] = mwd_w[i];
          end
          if (resp) begin
            chk($sformatf("rdata%0d", i), rdata_w[i], m_e[i].rdata);
            chk($sformatf("misaligned%0d", i), 32'(mis_w[i]), 32'(m_e[i].mis));
            chk($sformatf("illegal%0d", i), 32'(ill_w[i]), 32'(m_e[i].ill));
          end
          if (rspv_w[i]) begin
            last_lat[i] = cyc - acc[i];
            last_rdata[i] = rdata_w[i]; last_mis[i] = mis_w[i]; last_ill[i] = ill_w[i];
          end
        end
      end
    end
  end

  task automatic set_req(bit we, logic [2:0] f3, logic [31:0] a, logic [31:0] wd, logic [31:0] rw);
    req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; rd_word = rw;
  endtask

  task automatic send(int idx, bit we, logic [2:0] f3, logic [31:0] a, logic [31:0] wd, logic [31:0] rw);
    last_lat[idx] = -1; last_rdata[idx] = 32'h5A5A_5A5A;
    last_sel[idx] = 4'h0; last_maddr[idx] = 32'h0; last_mwd[idx] = 32'h0;
    @(posedge clk); #1;
    set_req(we, f3, a, wd, rw);
    rv[idx] = 1'b1;
    @(posedge clk); #1;
    rv[idx] = 1'b0;
    repeat (8) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; rv[0] = 1'b0; rv[1] = 1'b0;
    set_req(1'b0, 3'd0, 32'h0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(ready_w[0]), 32'd1);
    chk("rst_rsp_valid", 32'(rspv_w[0]), 32'd0);
    chk("rst_rdata", rdata_w[0], 32'h0);
    chk("rst_flags", {30'd0, mis_w[0], ill_w[0]}, 32'h0);
    chk("rst_wr_sel", 32'(sel_w[0]), 32'h0);
    chk("rst_mem_addr", maddr_w[0], 32'h0);
    chk("rst_wr_data", mwd_w[0], 32'h0);

    send(0, 1'b1, 3'b000, 32'h103, 32'h0000_00A5, 32'h0);
    chk("sb_sel", 32'(last_sel[0]), 32'h8);
    chk("sb_addr", last_maddr[0], 32'h100);
    chk("sb_data", last_mwd[0], 32'hA5A5_A5A5);
    chk("sb_lat", 32'(last_lat[0]), 32'd2);
    chk("sb_rdata", last_rdata[0], 32'h0);

    send(0, 1'b0, 3'b000, 32'h102, 32'h0, 32'h1280_3456);
    chk("lb_rdata", last_rdata[0], 32'hFFFF_FF80);
    chk("lb_lat", 32'(last_lat[0]), 32'd3);
    send(0, 1'b0, 3'b100, 32'h102, 32'h0, 32'h1280_3456);
    chk("lbu_rdata", last_rdata[0], 32'h0000_0080);
    send(0, 1'b0, 3'b001, 32'h102, 32'h0, 32'h8001_0000);
    chk("lh_rdata", last_rdata[0], 32'hFFFF_8001);
    send(0, 1'b0, 3'b101, 32'h102, 32'h0, 32'h8001_0000);
    chk("lhu_rdata", last_rdata[0], 32'h0000_8001);
    send(0, 1'b0, 3'b010, 32'h100, 32'h0, 32'h8001_0000);
    chk("lw_rdata", last_rdata[0], 32'h8001_0000);

    send(0, 1'b1, 3'b010, 32'h102, 32'h1111_2222, 32'h0);
    chk("sw_mis_flag", 32'(last_mis[0]), 32'd1);
    chk("sw_mis_lat", 32'(last_lat[0]), 32'd1);
    send(0, 1'b0, 3'b011, 32'h101, 32'h0, 32'h0);
    chk("ld_ill_flags", {30'd0, last_ill[0], last_mis[0]}, 32'h2);
    send(0, 1'b1, 3'b011, 32'h100, 32'h0, 32'h0);
    chk("st_ill_flag", 32'(last_ill[0]), 32'd1);

    send(0, 1'b1, 3'b001, 32'h102, 32'h1234_BEEF, 32'h0);
    chk("sh_sel", 32'(last_sel[0]), 32'hC);
    chk("sh_data", last_mwd[0], 32'hBEEF_BEEF);
    send(0, 1'b0, 3'b010, 32'hFFFF_FFFC, 32'h0, 32'hDEAD_BEEF);
    chk("wrap_addr", last_maddr[0], 32'hFFFF_FFFC);
    chk("wrap_rdata", last_rdata[0], 32'hDEAD_BEEF);

    // Latency-3 instance with req_valid held high across several transactions.
    last_lat[1] = -1;
    @(posedge clk); #1;
    set_req(1'b0, 3'b010, 32'h100, 32'h0, 32'h8001_0000);
    rv[1] = 1'b1;
    repeat (14) @(posedge clk);
    #1 rv[1] = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("lat3_lat", 32'(last_lat[1]), 32'd5);
    chk("lat3_rdata", last_rdata[1], 32'h8001_0000);

    // Reset landing in the WAIT cycle of a load.
    @(posedge clk); #1;
    set_req(1'b0, 3'b010, 32'h100, 32'h0, 32'h1357_9BDF);
    rv[0] = 1'b1;
    @(posedge clk); #1 rv[0] = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rstwait_ready", 32'(ready_w[0]), 32'd1);
    chk("rstwait_rsp", 32'(rspv_w[0]), 32'd0);
    repeat (4) @(posedge clk);
    send(0, 1'b0, 3'b010, 32'h104, 32'h0, 32'h2468_ACE0);
    chk("after_rst_lw", last_rdata[0], 32'h2468_ACE0);

    // Reset landing in the ISSUE cycle of a store: write still visible that cycle.
    @(posedge clk); #1;
    set_req(1'b1, 3'b010, 32'h200, 32'h1122_3344, 32'h0);
    rv[0] = 1'b1;
    @(posedge clk); #1 rv[0] = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    chk("rstiss_sel", 32'(sel_w[0]), 32'hF);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rstiss_sel_after", 32'(sel_w[0]), 32'h0);
    repeat (4) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
